// File: rtl/hex_arb_pkg.sv
// Shared types and helpers for the HEX display arbiter and its round-robin picker.
package hex_arb_pkg;

    localparam int DIGIT_W_DEFAULT = 16;
    localparam logic [DIGIT_W_DEFAULT-1:0] BLANK_WORD = 16'h0000;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request after
// index 'last', wrapping around, with 'last' itself considered at the end.
module rr_pick
    import hex_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [cnt_width(NUM_REQ)-1:0] last,
    output logic                          valid,
    output logic [cnt_width(NUM_REQ)-1:0] pick
);

    localparam int IW = cnt_width(NUM_REQ);

    logic [IW-1:0] idx;

    always_comb begin
        valid = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Time-sliced round-robin owner of the HEX digit bank: grants one requester,
// registers its digit word to the decoders and rotates on release or slice expiry.
module hex_display_arbiter
    import hex_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DIGIT_W      = DIGIT_W_DEFAULT,
    parameter int SLICE_CYCLES = 25000000
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ*DIGIT_W-1:0] data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [DIGIT_W-1:0]         hex_digits_out,
    output logic                       blank,
    output logic                       slice_expired
);

    localparam int IW = cnt_width(NUM_REQ);
    localparam int CW = cnt_width(SLICE_CYCLES);

    localparam logic [CW-1:0]      CNT_MAX   = CW'(SLICE_CYCLES - 1);
    localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
    localparam logic [DIGIT_W-1:0] BLANK     = DIGIT_W'(BLANK_WORD);

    arb_state_t         state, state_next;
    logic [IW-1:0]      last_owner, last_owner_next;
    logic [CW-1:0]      slice_cnt, slice_cnt_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [DIGIT_W-1:0] hex_next;
    logic               expired_next;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic               owner_req;
    logic               owner_lock;
    logic               others_waiting;
    logic               slice_done;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req  (req),
        .last (last_owner),
        .valid(pick_valid),
        .pick (pick_idx)
    );

    // While OWNED, last_owner is the current owner, so it indexes its req/lock bits.
    assign owner_req      = req[last_owner];
    assign owner_lock     = lock[last_owner];
    assign others_waiting = |(req & ~grant);
    assign slice_done     = (slice_cnt == CNT_MAX);

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_owner_next = last_owner;
        slice_cnt_next  = slice_cnt;
        expired_next    = 1'b0;
        hex_next        = BLANK;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next      = OWNED;
                    grant_next      = ONE_HOT0 << pick_idx;
                    last_owner_next = pick_idx;
                    slice_cnt_next  = '0;
                end
            end
            OWNED: begin
                hex_next = data[int'(last_owner)*DIGIT_W +: DIGIT_W];
                if (!owner_req) begin
                    // A release takes priority over expiry, so no pulse here.
                    if (pick_valid) begin
                        grant_next      = ONE_HOT0 << pick_idx;
                        last_owner_next = pick_idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        hex_next   = BLANK;
                    end
                    slice_cnt_next = '0;
                end else if (slice_done && !owner_lock && others_waiting) begin
                    grant_next      = ONE_HOT0 << pick_idx;
                    last_owner_next = pick_idx;
                    slice_cnt_next  = '0;
                    expired_next    = 1'b1;
                end else if (!slice_done) begin
                    slice_cnt_next = slice_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            grant          <= '0;
            last_owner     <= LAST_INIT;
            slice_cnt      <= '0;
            slice_expired  <= 1'b0;
            blank          <= 1'b1;
            hex_digits_out <= BLANK;
        end else begin
            state          <= state_next;
            grant          <= grant_next;
            last_owner     <= last_owner_next;
            slice_cnt      <= slice_cnt_next;
            slice_expired  <= expired_next;
            blank          <= (state_next == IDLE);
            hex_digits_out <= hex_next;
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with NUM_REQ=3, SLICE_CYCLES=4.
// Observed word per cycle: {grant[2:0], blank, slice_expired, hex_digits_out[15:0]}.
module tb_hex_display_arbiter;

    logic        Clk;
    logic        Reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [15:0] d0, d1, d2;
    wire  [47:0] data = {d2, d1, d0};
    logic [2:0]  grant;
    logic [15:0] hex_digits_out;
    logic        blank;
    logic        slice_expired;

    wire  [20:0] obs = {grant, blank, slice_expired, hex_digits_out};

    int checks = 0;
    int errors = 0;

    hex_display_arbiter #(
        .NUM_REQ     (3),
        .DIGIT_W     (16),
        .SLICE_CYCLES(4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .req           (req),
        .lock          (lock),
        .data          (data),
        .grant         (grant),
        .hex_digits_out(hex_digits_out),
        .blank         (blank),
        .slice_expired (slice_expired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== {3'b000, 1'b1, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, obs, {3'b000, 1'b1, 1'b0, 16'h0000});
            end
        end
    endtask

    task automatic test_first_grant();
        logic [20:0] exp_v [3];
        exp_v = '{{3'b001, 1'b0, 1'b0, 16'h0000},
                  {3'b001, 1'b0, 1'b0, 16'h1234},
                  {3'b001, 1'b0, 1'b0, 16'hABCD}};
        req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL first_grant[%0d]: got %h want %h", i, obs, exp_v[i]);
            end
            if (i == 1) d0 = 16'hABCD;
        end
    endtask

    task automatic test_slice_expiry();
        logic [20:0] exp_v [7];
        exp_v = '{{3'b001, 1'b0, 1'b0, 16'hABCD},
                  {3'b100, 1'b0, 1'b1, 16'hABCD},
                  {3'b100, 1'b0, 1'b0, 16'hCCCC},
                  {3'b100, 1'b0, 1'b0, 16'hCCCC},
                  {3'b100, 1'b0, 1'b0, 16'hCCCC},
                  {3'b001, 1'b0, 1'b1, 16'hCCCC},
                  {3'b001, 1'b0, 1'b0, 16'hABCD}};
        req = 3'b101;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL slice_expiry[%0d]: got %h want %h", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_lock();
        req  = 3'b011;
        lock = 3'b001;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== {3'b001, 1'b0, 1'b0, 16'hABCD}) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got %h want %h", i, obs, {3'b001, 1'b0, 1'b0, 16'hABCD});
            end
        end
        req = 3'b010;
        tick();
        checks++;
        if (obs !== {3'b010, 1'b0, 1'b0, 16'hABCD}) begin
            errors++;
            $display("FAIL lock_release: got %h want %h", obs, {3'b010, 1'b0, 1'b0, 16'hABCD});
        end
        tick();
        checks++;
        if (obs !== {3'b010, 1'b0, 1'b0, 16'h5678}) begin
            errors++;
            $display("FAIL lock_release_data: got %h want %h", obs, {3'b010, 1'b0, 1'b0, 16'h5678});
        end
        lock = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  req_v [8];
        logic [20:0] exp_v [8];
        req_v = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b010};
        exp_v = '{{3'b010, 1'b0, 1'b0, 16'h5678},
                  {3'b010, 1'b0, 1'b0, 16'h5678},
                  {3'b010, 1'b0, 1'b0, 16'h5678},
                  {3'b001, 1'b0, 1'b1, 16'h5678},
                  {3'b001, 1'b0, 1'b0, 16'hABCD},
                  {3'b001, 1'b0, 1'b0, 16'hABCD},
                  {3'b001, 1'b0, 1'b0, 16'hABCD},
                  {3'b010, 1'b0, 1'b0, 16'hABCD}};
        for (int i = 0; i < 8; i++) begin
            req = req_v[i];
            tick();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_idle_rerequest();
        logic [2:0]  req_v [7];
        logic [20:0] exp_v [7];
        req_v = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b011};
        exp_v = '{{3'b010, 1'b0, 1'b0, 16'h5678},
                  {3'b000, 1'b1, 1'b0, 16'h0000},
                  {3'b000, 1'b1, 1'b0, 16'h0000},
                  {3'b010, 1'b0, 1'b0, 16'h0000},
                  {3'b010, 1'b0, 1'b0, 16'h5678},
                  {3'b000, 1'b1, 1'b0, 16'h0000},
                  {3'b001, 1'b0, 1'b0, 16'h0000}};
        for (int i = 0; i < 7; i++) begin
            req = req_v[i];
            tick();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL idle_rerequest[%0d]: got %h want %h", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [2:0]  req_v [4];
        logic        rst_v [4];
        logic [20:0] exp_v [4];
        req_v = '{3'b110, 3'b111, 3'b111, 3'b111};
        rst_v = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_v = '{{3'b010, 1'b0, 1'b0, 16'hABCD},
                  {3'b000, 1'b1, 1'b0, 16'h0000},
                  {3'b001, 1'b0, 1'b0, 16'h0000},
                  {3'b001, 1'b0, 1'b0, 16'hABCD}};
        for (int i = 0; i < 4; i++) begin
            req   = req_v[i];
            Reset = rst_v[i];
            tick();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_mid_grant[%0d]: got %h want %h", i, obs, exp_v[i]);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;
        d0    = 16'h1234;
        d1    = 16'h5678;
        d2    = 16'hCCCC;
        test_reset();
        test_first_grant();
        test_slice_expiry();
        test_lock();
        test_back_to_back();
        test_idle_rerequest();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
